mem_arbiter: RTL

Two-port arbiter that shares a single byte-addressed, word-wide MEMORY instance between the instruction-fetch port and the load/store port of the core. Each cycle it grants at most one requester and drives the memory's read/write addresses, write data and write enable from the granted requester. It registers read data back to the granted requester one cycle later. It sits between the core's fetch/LSU logic and the unified memory.

---
 rtl/mem_arbiter.sv | 101 ++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / load-store) arbiter in front of a single word-wide memory port.
// Define MEM_ARB_RR_EN for round-robin on contention; default build gives load/store fixed priority.
module mem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] m_raddr,
  output logic [ADDR_W-1:0] m_waddr,
  output logic [DATA_W-1:0] m_wd,
  output logic              m_we,
  input  logic [DATA_W-1:0] m_rd
);

`ifdef MEM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  // last_reg: 0 = fetch granted most recently, 1 = load/store granted most recently
  logic last_reg;
  logic last_next;
  logic i_rvalid_reg;
  logic d_rvalid_reg;
  logic [DATA_W-1:0] i_rdata_reg;
  logic [DATA_W-1:0] d_rdata_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_reg     <= 1'b1;
      i_rvalid_reg <= 1'b0;
      d_rvalid_reg <= 1'b0;
      i_rdata_reg  <= '0;
      d_rdata_reg  <= '0;
    end else begin
      last_reg     <= last_next;
      i_rvalid_reg <= i_gnt;
      d_rvalid_reg <= d_gnt & ~d_we;
      if (i_gnt) begin
        i_rdata_reg <= m_rd;
      end
      if (d_gnt && !d_we) begin
        d_rdata_reg <= m_rd;
      end
    end
  end

  always_comb begin
    last_next = last_reg;
    if (i_gnt || d_gnt) begin
      last_next = d_gnt;
    end
  end

  // Grants and memory drive; on contention fetch wins only in round-robin mode after a load/store grant.
  always_comb begin
    i_gnt   = 1'b0;
    d_gnt   = 1'b0;
    m_raddr = '0;
    m_waddr = '0;
    m_wd    = '0;
    m_we    = 1'b0;
    if (!rst) begin
      if (i_req && d_req) begin
        i_gnt = RR_EN & last_reg;
        d_gnt = ~(RR_EN & last_reg);
      end else begin
        i_gnt = i_req;
        d_gnt = d_req;
      end
    end
    if (i_gnt) begin
      m_raddr = i_addr;
    end else if (d_gnt) begin
      m_raddr = d_addr;
      m_waddr = d_addr;
      m_wd    = d_wdata;
      m_we    = d_we;
    end
  end

  assign i_rvalid = i_rvalid_reg;
  assign i_rdata  = i_rdata_reg;
  assign d_rvalid = d_rvalid_reg;
  assign d_rdata  = d_rdata_reg;

endmodule
